// File: rtl/csr_issue.sv
// CSR instruction issue block: decodes SYSTEM-opcode CSR instructions, issues one request, writes back the old value.
// Optional request timeout enabled by defining CSR_ISSUE_TIMEOUT_EN.
module csr_issue #(
  parameter int XLEN         = 32,
  parameter int CSR_ADDR     = 12,
  parameter int CSR_OP_WIDTH = 3,
  parameter int TIMEOUT      = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid_i,
  output logic                    instr_ready_o,
  input  logic [31:0]             instr_i,
  input  logic [XLEN-1:0]         rs1_val_i,
  output logic                    csr_req_o,
  output logic [CSR_ADDR-1:0]     csr_addr_o,
  output logic [CSR_OP_WIDTH-1:0] csr_op_o,
  output logic [XLEN-1:0]         csr_val_o,
  input  logic                    csr_ack_i,
  input  logic [XLEN-1:0]         csr_rdata_i,
  output logic                    wb_valid_o,
  output logic [4:0]              wb_rd_o,
  output logic [XLEN-1:0]         wb_data_o,
  output logic                    illegal_o,
  output logic                    timeout_o,
  output logic [1:0]              dbg_state_o
);

  // Handshake: an instruction transfers on a rising edge where instr_valid_i and
  // instr_ready_o are both 1; the offer may change freely while ready is 0.
  // The CSR side holds csr_req_o and its fields until csr_ack_i is seen in REQ.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t state;

  logic                    dec_legal;
  logic [CSR_OP_WIDTH-1:0] dec_op;
  logic [XLEN-1:0]         dec_val;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = '0;
    if (instr_i[6:0] == 7'b1110011) begin
      case (instr_i[14:12])
        3'b001:  begin dec_legal = 1'b1; dec_op = CSR_OP_WIDTH'(1); end
        3'b010:  begin dec_legal = 1'b1; dec_op = CSR_OP_WIDTH'(2); end
        3'b011:  begin dec_legal = 1'b1; dec_op = CSR_OP_WIDTH'(3); end
        3'b101:  begin dec_legal = 1'b1; dec_op = CSR_OP_WIDTH'(4); end
        3'b110:  begin dec_legal = 1'b1; dec_op = CSR_OP_WIDTH'(5); end
        3'b111:  begin dec_legal = 1'b1; dec_op = CSR_OP_WIDTH'(6); end
        default: begin dec_legal = 1'b0; dec_op = '0; end
      endcase
    end
    // funct3[2] selects the immediate forms, whose operand is the zero-extended rs1 field
    dec_val = instr_i[14] ? {{(XLEN-5){1'b0}}, instr_i[19:15]} : rs1_val_i;
  end

`ifdef CSR_ISSUE_TIMEOUT_EN
  logic [3:0] wait_cnt;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      instr_ready_o <= 1'b1;
      csr_req_o     <= 1'b0;
      csr_addr_o    <= '0;
      csr_op_o      <= '0;
      csr_val_o     <= '0;
      wb_valid_o    <= 1'b0;
      wb_rd_o       <= '0;
      wb_data_o     <= '0;
      illegal_o     <= 1'b0;
`ifdef CSR_ISSUE_TIMEOUT_EN
      timeout_o     <= 1'b0;
      wait_cnt      <= '0;
`endif
    end else begin
      wb_valid_o <= 1'b0;
      illegal_o  <= 1'b0;
`ifdef CSR_ISSUE_TIMEOUT_EN
      timeout_o  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (instr_valid_i && instr_ready_o) begin
            instr_ready_o <= 1'b0;
            if (dec_legal) begin
              state      <= REQ;
              csr_req_o  <= 1'b1;
              csr_addr_o <= instr_i[31:20];
              csr_op_o   <= dec_op;
              csr_val_o  <= dec_val;
              wb_rd_o    <= instr_i[11:7];
`ifdef CSR_ISSUE_TIMEOUT_EN
              wait_cnt   <= '0;
`endif
            end else begin
              state     <= ERR;
              illegal_o <= 1'b1;
            end
          end
        end
        REQ: begin
          // an ack in the expiry cycle takes priority over the timeout
          if (csr_ack_i) begin
            state      <= WB;
            csr_req_o  <= 1'b0;
            csr_op_o   <= '0;
            wb_data_o  <= csr_rdata_i;
            wb_valid_o <= (wb_rd_o != 5'd0);
          end
`ifdef CSR_ISSUE_TIMEOUT_EN
          else if (wait_cnt == 4'(TIMEOUT - 1)) begin
            state     <= ERR;
            csr_req_o <= 1'b0;
            csr_op_o  <= '0;
            timeout_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
`endif
        end
        WB: begin
          state         <= IDLE;
          instr_ready_o <= 1'b1;
        end
        ERR: begin
          state         <= IDLE;
          instr_ready_o <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          instr_ready_o <= 1'b1;
        end
      endcase
    end
  end

  assign dbg_state_o = state;

endmodule

// File: tb/tb_csr_issue.sv
// Directed bench for csr_issue: hand-computed vectors, writeback scoreboard, pulse counters.
// Define CSR_ISSUE_TIMEOUT_EN for both bench and RTL to cover the timeout path.
module tb_csr_issue;

  logic        clk;
  logic        rst;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [31:0] rs1_val_i;
  logic        csr_req_o;
  logic [11:0] csr_addr_o;
  logic [2:0]  csr_op_o;
  logic [31:0] csr_val_o;
  logic        csr_ack_i;
  logic [31:0] csr_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        illegal_o;
  logic        timeout_o;
  logic [1:0]  dbg_state_o;

  int total = 0;
  int bad   = 0;
  int illegal_cnt = 0;
  int timeout_cnt = 0;
  logic [36:0] exp_q[$];

  csr_issue #(.XLEN(32), .CSR_ADDR(12), .CSR_OP_WIDTH(3), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .rs1_val_i(rs1_val_i),
    .csr_req_o(csr_req_o), .csr_addr_o(csr_addr_o), .csr_op_o(csr_op_o),
    .csr_val_o(csr_val_o), .csr_ack_i(csr_ack_i), .csr_rdata_i(csr_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .illegal_o(illegal_o), .timeout_o(timeout_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [11:0] csr, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [4:0] rd,
                                     input logic [6:0] opc);
    return {csr, rs1, f3, rd, opc};
  endfunction

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] rs1);
    check("ready_before_issue", instr_ready_o, 1);
    instr_valid_i = 1'b1;
    instr_i       = ins;
    rs1_val_i     = rs1;
    tick();
    instr_valid_i = 1'b0;
    instr_i       = 32'h0;
  endtask

  // scoreboard: every wb_valid_o pulse must match the oldest expected {rd, data}
  always @(negedge clk) begin
    if (wb_valid_o) begin
      if (exp_q.size() == 0) check("wb_unexpected", {wb_rd_o, wb_data_o}, 0);
      else check("wb_scoreboard", {wb_rd_o, wb_data_o}, exp_q.pop_front());
    end
    if (illegal_o) illegal_cnt++;
    if (timeout_o) timeout_cnt++;
  end

  initial begin
    rst = 1'b1; instr_valid_i = 1'b0; instr_i = 32'h0; rs1_val_i = 32'h0;
    csr_ack_i = 1'b0; csr_rdata_i = 32'h0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_ready", instr_ready_o, 1);
    check("rst_req", csr_req_o, 0);
    check("rst_addr", csr_addr_o, 0);
    check("rst_op", csr_op_o, 0);
    check("rst_val", csr_val_o, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_rd", wb_rd_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_illegal", illegal_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_state", dbg_state_o, 0);

    // CSRRS x5, 0xC00, x6 with fastest ack
    issue(mk(12'hC00, 5'd6, 3'b010, 5'd5, 7'h73), 32'h0000_00F0);
    check("rs_req", csr_req_o, 1);
    check("rs_ready", instr_ready_o, 0);
    check("rs_addr", csr_addr_o, 12'hC00);
    check("rs_op", csr_op_o, 2);
    check("rs_val", csr_val_o, 32'hF0);
    csr_ack_i = 1'b1; csr_rdata_i = 32'h1234;
    exp_q.push_back({5'd5, 32'h1234});
    tick();
    csr_ack_i = 1'b0;
    check("rs_wb_valid", wb_valid_o, 1);
    check("rs_wb_rd", wb_rd_o, 5);
    check("rs_wb_data", wb_data_o, 32'h1234);
    check("rs_req_wb", csr_req_o, 0);
    check("rs_op_wb", csr_op_o, 0);
    tick();
    check("rs_ready_again", instr_ready_o, 1);
    check("rs_wb_once", wb_valid_o, 0);

    // CSRRWI x0, 0xC80, zimm=31: no writeback to x0
    issue(mk(12'hC80, 5'd31, 3'b101, 5'd0, 7'h73), 32'hDEAD_BEEF);
    check("rwi_op", csr_op_o, 4);
    check("rwi_val", csr_val_o, 32'h1F);
    check("rwi_addr", csr_addr_o, 12'hC80);
    csr_ack_i = 1'b1; csr_rdata_i = 32'h55;
    tick();
    csr_ack_i = 1'b0;
    check("rwi_wb_x0", wb_valid_o, 0);
    tick();
    check("rwi_ready", instr_ready_o, 1);

    // illegal funct3=100
    issue(mk(12'h300, 5'd1, 3'b100, 5'd3, 7'h73), 32'h1);
    check("ill1_pulse", illegal_o, 1);
    check("ill1_req", csr_req_o, 0);
    check("ill1_ready", instr_ready_o, 0);
    tick();
    check("ill1_pulse_end", illegal_o, 0);
    check("ill1_ready_back", instr_ready_o, 1);

    // illegal opcode 0x33
    issue(mk(12'h300, 5'd1, 3'b001, 5'd3, 7'h33), 32'h1);
    check("ill2_pulse", illegal_o, 1);
    check("ill2_req", csr_req_o, 0);
    tick();
    check("ill2_ready_back", instr_ready_o, 1);
    check("ill2_wb", wb_valid_o, 0);

    // spurious ack in IDLE, then CSRRC x7, 0x300 with ack in the 7th REQ cycle
    csr_ack_i = 1'b1; csr_rdata_i = 32'hBAD;
    tick();
    csr_ack_i = 1'b0;
    check("spur_ready", instr_ready_o, 1);
    check("spur_state", dbg_state_o, 0);
    issue(mk(12'h300, 5'd1, 3'b011, 5'd7, 7'h73), 32'h0000_A5A5);
    for (int i = 0; i < 7; i++) begin
      check("slow_req", csr_req_o, 1);
      check("slow_fields", {csr_addr_o, csr_op_o, csr_val_o}, {12'h300, 3'd3, 32'h0000_A5A5});
      if (i == 6) begin
        csr_ack_i = 1'b1; csr_rdata_i = 32'h77;
        exp_q.push_back({5'd7, 32'h77});
      end
      tick();
    end
    csr_ack_i = 1'b0;
    check("slow_wb_valid", wb_valid_o, 1);
    check("slow_wb_data", wb_data_o, 32'h77);
    tick();
    check("slow_wb_once", wb_valid_o, 0);

    // reset during REQ abandons the request
    issue(mk(12'h341, 5'd2, 3'b001, 5'd9, 7'h73), 32'h42);
    check("rstreq_req", csr_req_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstreq_req_off", csr_req_o, 0);
    check("rstreq_ready", instr_ready_o, 1);
    csr_ack_i = 1'b1; csr_rdata_i = 32'h99;
    tick();
    csr_ack_i = 1'b0;
    check("rstreq_no_wb", wb_valid_o, 0);
    tick();

`ifdef CSR_ISSUE_TIMEOUT_EN
    // no ack: timeout after 15 REQ cycles
    issue(mk(12'h305, 5'd0, 3'b110, 5'd4, 7'h73), 32'h0);
    for (int i = 0; i < 15; i++) begin
      check("to_req_held", csr_req_o, 1);
      tick();
    end
    check("to_pulse", timeout_o, 1);
    check("to_req_off", csr_req_o, 0);
    check("to_no_wb", wb_valid_o, 0);
    tick();
    check("to_pulse_end", timeout_o, 0);
    check("to_ready", instr_ready_o, 1);
    // ack on the 15th cycle wins
    issue(mk(12'h305, 5'd0, 3'b111, 5'd4, 7'h73), 32'h0);
    for (int i = 0; i < 15; i++) begin
      check("to2_req_held", csr_req_o, 1);
      if (i == 14) begin
        csr_ack_i = 1'b1; csr_rdata_i = 32'hCAFE;
        exp_q.push_back({5'd4, 32'hCAFE});
      end
      tick();
    end
    csr_ack_i = 1'b0;
    check("to2_wb", wb_valid_o, 1);
    check("to2_no_pulse", timeout_o, 0);
    tick();
    check("timeout_pulses", timeout_cnt, 1);
`else
    // without the timeout the request waits indefinitely
    issue(mk(12'h305, 5'd0, 3'b110, 5'd4, 7'h73), 32'h0);
    for (int i = 0; i < 20; i++) begin
      check("wait_req_held", {csr_req_o, timeout_o}, 2'b10);
      tick();
    end
    csr_ack_i = 1'b1; csr_rdata_i = 32'hCAFE;
    exp_q.push_back({5'd4, 32'hCAFE});
    tick();
    csr_ack_i = 1'b0;
    check("wait_wb", wb_valid_o, 1);
    tick();
    check("timeout_pulses", timeout_cnt, 0);
`endif

    // final report
    tick();
    check("illegal_pulses", illegal_cnt, 2);
    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_issue.md
CSR_ISSUE -- requirements
Module: csr_issue

Interface
REQ-001 Parameters (name, default, meaning): XLEN, 32, data width; CSR_ADDR, 12, CSR address width; CSR_OP_WIDTH, 3, op code width; TIMEOUT, 15, maximum wait cycles for an ack (range 1..15).
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 instr_valid_i  in  1  the instruction/rs1 pair is offered.
REQ-005 instr_ready_o  out  1  the block can accept an instruction.
REQ-006 instr_i  in  32  SYSTEM-opcode instruction word.
REQ-007 rs1_val_i  in  XLEN  rs1 register value.
REQ-008 csr_req_o  out  1  request to the CSR unit.
REQ-009 csr_addr_o  out  CSR_ADDR  CSR address, equal to instr[31:20].
REQ-010 csr_op_o  out  CSR_OP_WIDTH  encoding: 1 CSRRW, 2 CSRRS, 3 CSRRC, 4 CSRRWI, 5 CSRRSI, 6 CSRRCI.
REQ-011 csr_val_o  out  XLEN  operand: rs1_val for ops 1-3; zero-extended zimm (instr[19:15]) for ops 4-6.
REQ-012 csr_ack_i  in  1  the CSR unit has completed the request.
REQ-013 csr_rdata_i  in  XLEN  old CSR value; valid while csr_ack_i=1.
REQ-014 wb_valid_o  out  1  one-cycle register-file write strobe.
REQ-015 wb_rd_o  out  5  destination register, equal to instr[11:7].
REQ-016 wb_data_o  out  XLEN  writeback data.
REQ-017 illegal_o  out  1  one-cycle pulse: the instruction was rejected.
REQ-018 timeout_o  out  1  one-cycle pulse: the request was abandoned.

Function
REQ-019 The FSM SHALL have four states: IDLE, REQ, WB and ERR. instr_ready_o SHALL be 1 only in IDLE.
REQ-020 An instruction SHALL be accepted on a cycle where instr_valid_i and instr_ready_o are both 1; addr, op, operand and rd SHALL be latched at that edge.
REQ-021 An instruction SHALL be legal only if opcode (instr[6:0]) is 7'b1110011 and funct3 (instr[14:12]) is one of 001/010/011/101/110/111, mapping to ops 1-6 in that order.
REQ-022 An accepted legal instruction SHALL move IDLE->REQ. An accepted illegal one SHALL move IDLE->ERR with illegal_o=1, and issue no request and no writeback.
REQ-023 In REQ: csr_req_o=1, and csr_addr_o, csr_op_o and csr_val_o SHALL hold their latched values, stable until ack.
REQ-024 csr_ack_i sampled at 1 in REQ SHALL capture csr_rdata_i and move the FSM to WB. An ack in the first REQ cycle is valid. Acks in any other state SHALL be ignored.
REQ-025 In WB, wb_data_o SHALL be the captured data and wb_valid_o=1 for exactly one cycle, except that wb_valid_o SHALL be 0 when rd=0. WB->IDLE unconditionally.
REQ-026 ERR SHALL last exactly one cycle and then move to IDLE.
REQ-027 Minimum latency: accept at edge N; csr_req_o high during cycle N+1; with ack in that cycle, WB during N+2 and instr_ready_o=1 again in N+3.
REQ-028 When the FSM is not in REQ, csr_req_o SHALL be 0 and csr_op_o SHALL be 0.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE and abandon any operation in flight, with no writeback and no pulse.
REQ-030 Reset values: instr_ready_o=1 (after reset, in IDLE); csr_req_o, wb_valid_o, illegal_o and timeout_o all 0; csr_addr_o, csr_op_o, csr_val_o, wb_rd_o and wb_data_o all zero.

Configuration
REQ-031 With macro CSR_ISSUE_TIMEOUT_EN defined: a 4-bit counter SHALL clear on entry to REQ and increment each REQ cycle without an ack.
- After TIMEOUT such cycles, REQ SHALL move to ERR with timeout_o=1 and no writeback.
- An ack in the same cycle as expiry SHALL win.
REQ-032 Without the macro: REQ SHALL wait indefinitely, no counter SHALL exist, and timeout_o SHALL be tied to 0.

Verification
REQ-033 CSRRS x5, 0xC00, x6 with rs1=0x0000_00F0 and ack in the first REQ cycle returning 0x1234 -> csr_op_o=2, csr_val_o=0xF0; wb_valid_o at N+2 with wb_rd_o=5 and wb_data_o=0x1234.
REQ-034 CSRRWI x0, 0xC80, zimm=31 -> csr_op_o=4, csr_val_o=0x1F; after ack, wb_valid_o stays 0.
REQ-035 funct3=100, or opcode 0x33 -> illegal_o pulses once, csr_req_o never asserts, and instr_ready_o returns to 1 after 2 cycles.
REQ-036 Ack delayed 7 cycles, with a spurious ack in IDLE beforehand -> the spurious ack is ignored; csr_req_o is held 7 cycles with fields stable; exactly one wb_valid_o pulse.
REQ-037 rst asserted during REQ -> next cycle csr_req_o=0 and instr_ready_o=1; a later ack produces no writeback.
REQ-038 CSR_ISSUE_TIMEOUT_EN defined, TIMEOUT=15, no ack -> timeout_o pulses after 15 REQ cycles with no writeback; an ack on the 15th cycle gives a normal writeback and no timeout_o pulse.
